// File: rtl/div_result_fifo.sv
// Result FIFO that buffers quotient/remainder pairs coming out of the pipelined divider.
// Latency: first-word-fall-through; an entry pushed on edge k is at the head from edge k.
// Backpressure: none towards the divider; a result arriving while full with no pop is dropped.
// Optional build macro DIV_RESULT_FIFO_OVF_EN enables the sticky OVF drop flag (otherwise OVF=0).

module div_result_fifo #(
    parameter int tamanyo     = 32,
    parameter int profundidad = 8
) (
    input  logic                           CLK,
    input  logic                           RSTa,
    input  logic                           Done_in,
    input  logic [tamanyo-1:0]             Coc_in,
    input  logic [tamanyo-1:0]             Res_in,
    input  logic                           Out_ready,
    input  logic                           Clr_ovf,
    output logic                           Out_valid,
    output logic [tamanyo-1:0]             Coc_out,
    output logic [tamanyo-1:0]             Res_out,
    output logic [$clog2(profundidad):0]   Count,
    output logic                           Full,
    output logic                           Empty,
    output logic                           OVF
);

    localparam int PW = $clog2(profundidad);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [tamanyo-1:0] coc;
        logic [tamanyo-1:0] res;
    } entry_t;

    entry_t          mem_q [profundidad];
    entry_t          mem_d [profundidad];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            drop;

    // Occupancy flags come straight from the registered count, so nothing here
    // depends combinationally on Done_in.
    always_comb begin
        full  = (count_q == CW'(profundidad));
        empty = (count_q == '0);
    end

    // Push/pop decision, storage write and pointer/count bookkeeping.
    // A pop on the same edge frees a slot, so a full FIFO can still accept a result.
    always_comb begin
        pop      = !empty && Out_ready;
        push     = Done_in && (!full || pop);
        drop     = Done_in && !push;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{coc: Coc_in, res: Res_in};
            // Depth is a power of two, so the natural wrap of the pointer is gap-free.
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef DIV_RESULT_FIFO_OVF_EN
    // Sticky drop flag: a drop wins over a coincident clear so no loss goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (Clr_ovf) begin
            ovf_d = 1'b0;
        end
    end
`else
    // Flag not built: it stays at zero and both the clear and the drop event go unused.
    logic unused_ovf_inputs;
    always_comb begin
        ovf_d             = 1'b0;
        unused_ovf_inputs = Clr_ovf | drop;
    end
`endif

    // State registers; reset is asynchronous and also scrubs the storage array.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Head presentation; data outputs are forced to zero whenever nothing is stored.
    always_comb begin
        Out_valid = !empty;
        Coc_out   = empty ? '0 : mem_q[rd_ptr_q].coc;
        Res_out   = empty ? '0 : mem_q[rd_ptr_q].res;
        Count     = count_q;
        Full      = full;
        Empty     = empty;
        OVF       = ovf_q;
    end

endmodule
